add_subt_pipe: RTL and testbench



---
 rtl/add_subt_pipe.sv | 186 ++++++++++++++++++
 tb/tb_add_subt_pipe.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_subt_pipe.sv
// ---------------------------------------------------------------------------
// add_subt_pipe
//
// Pipelined unsigned significand adder/subtractor for the FP add/sub
// datapath. The SWR-bit operation is split into STAGES carry-chained chunks
// of CW = ceil(SWR/STAGES) bits, one chunk per stage. A single global
// advance enable gives a valid/ready handshake with backpressure. The result
// feeds the LZD/normaliser stage.
//
// Parameters
//   SWR     operand/result width, 2..64
//   STAGES  pipeline depth and chunk count, 1..SWR
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous reset, active-low
//   valid_i        input operands valid
//   ready_o        pipe accepts input this cycle (combinational)
//   Add_Sub_op_i   0 = A+B, 1 = A-B
//   Data_A_i       operand A, unsigned
//   Data_B_i       operand B, unsigned
//   valid_o        result valid
//   ready_i        downstream accepts result
//   Data_Result_o  sum/difference modulo 2^SWR (magnitude with ABS_RESULT_EN)
//   FSM_C_o        raw carry-out of the MSB; for subtract 1 means A >= B
//   Zero_o         Data_Result_o == 0
//   Neg_o          subtract with A < B (only with ABS_RESULT_EN)
//
// Build option
//   ABS_RESULT_EN  when defined, a negative difference is replaced by its
//                  two's-complement magnitude in the final stage and Neg_o
//                  is added. When undefined, the raw result is output and
//                  Neg_o does not exist.
// ---------------------------------------------------------------------------
module add_subt_pipe #(
    parameter int SWR    = 26,
    parameter int STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           valid_i,
    output logic           ready_o,
    input  logic           Add_Sub_op_i,
    input  logic [SWR-1:0] Data_A_i,
    input  logic [SWR-1:0] Data_B_i,
    output logic           valid_o,
    input  logic           ready_i,
    output logic [SWR-1:0] Data_Result_o,
    output logic           FSM_C_o,
`ifdef ABS_RESULT_EN
    output logic           Neg_o,
`endif
    output logic           Zero_o
);

    // Operands are zero-padded to PW = CW*STAGES bits so every stage works on
    // a full CW-bit chunk. Padding bits of B are never inverted, so the padded
    // sum bit at position SWR is exactly the carry out of bit SWR-1.
    localparam int            CW       = (SWR + STAGES - 1) / STAGES;
    localparam int            PW       = CW * STAGES;
    localparam logic [PW-1:0] INV_MASK = PW'({SWR{1'b1}});

    // Global stall: the whole pipe moves only when the output slot is free
    // or being consumed.
    logic adv;
    assign adv     = ready_i | ~valid_o;
    assign ready_o = adv;

    // Index k holds the inputs seen by stage k: ports for k = 0, the
    // registers of stage k-1 otherwise.
    logic [PW-1:0] a_s  [STAGES];
    logic [PW-1:0] b_s  [STAGES];
    logic [PW-1:0] s_s  [STAGES];
    logic          op_s [STAGES];
    logic          c_s  [STAGES];
    logic          v_s  [STAGES];

    assign a_s[0]  = PW'(Data_A_i);
    assign b_s[0]  = PW'(Data_B_i);
    assign s_s[0]  = '0;
    assign op_s[0] = Add_Sub_op_i;
    assign c_s[0]  = Add_Sub_op_i;   // the +1 of A + ~B + 1
    assign v_s[0]  = valid_i;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CW-1:0] b_chunk;
        logic [CW:0]   chunk_sum;
        logic [PW-1:0] s_next;

        assign b_chunk   = b_s[k][k*CW +: CW] ^ ({CW{op_s[k]}} & INV_MASK[k*CW +: CW]);
        assign chunk_sum = {1'b0, a_s[k][k*CW +: CW]} + {1'b0, b_chunk}
                         + {{CW{1'b0}}, c_s[k]};

        // Lower chunks finished by earlier stages pass through; this stage
        // fills in its own chunk.
        // NOTE: s_next gets a full default before the partial overwrite, so
        // no bit is left unassigned on any path and no latch is inferred.
        always_comb begin
            s_next               = s_s[k];
            s_next[k*CW +: CW]   = chunk_sum[CW-1:0];
        end

        if (k < STAGES - 1) begin : g_mid
            logic [PW-1:0] a_q;
            logic [PW-1:0] b_q;
            logic [PW-1:0] s_q;
            logic          op_q;
            logic          c_q;
            logic          v_q;

            // NOTE: state registers use non-blocking assignments so every
            // stage samples its neighbour's pre-edge value.
            // NOTE: datapath registers are reset along with the valids; it is
            // cheap here and keeps reset state fully deterministic.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    a_q  <= '0;
                    b_q  <= '0;
                    s_q  <= '0;
                    op_q <= 1'b0;
                    c_q  <= 1'b0;
                    v_q  <= 1'b0;
                end else if (adv) begin
                    a_q  <= a_s[k];
                    b_q  <= b_s[k];
                    s_q  <= s_next;
                    op_q <= op_s[k];
                    c_q  <= chunk_sum[CW];
                    v_q  <= v_s[k];
                end
            end

            assign a_s[k+1]  = a_q;
            assign b_s[k+1]  = b_q;
            assign s_s[k+1]  = s_q;
            assign op_s[k+1] = op_q;
            assign c_s[k+1]  = c_q;
            assign v_s[k+1]  = v_q;
        end else begin : g_last
            logic [PW:0]    full;
            logic [SWR-1:0] raw;
            logic [SWR-1:0] res;
            logic           carry;

            // When PW > SWR the final chunk carry is 0 and bit SWR of the
            // padded sum carries the real carry-out; when PW == SWR it is the
            // chunk carry itself. Concatenating covers both cases.
            assign full  = {chunk_sum[CW], s_next};
            assign raw   = full[SWR-1:0];
            assign carry = full[SWR];

`ifdef ABS_RESULT_EN
            logic neg;
            assign neg = op_s[k] & ~carry;
            assign res = neg ? (~raw + SWR'(1)) : raw;
`else
            assign res = raw;
`endif

            // Output registers only load on a valid entry, so bubbles drop
            // valid_o but leave the last result visible.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    valid_o       <= 1'b0;
                    Data_Result_o <= '0;
                    FSM_C_o       <= 1'b0;
                    Zero_o        <= 1'b0;
`ifdef ABS_RESULT_EN
                    Neg_o         <= 1'b0;
`endif
                end else if (adv) begin
                    valid_o <= v_s[k];
                    if (v_s[k]) begin
                        Data_Result_o <= res;
                        FSM_C_o       <= carry;
                        Zero_o        <= (res == '0);
`ifdef ABS_RESULT_EN
                        Neg_o         <= neg;
`endif
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_add_subt_pipe.sv
// ---------------------------------------------------------------------------
// tb_add_subt_pipe
//
// Directed bench for add_subt_pipe. The main instance uses SWR=26, STAGES=2;
// two further instances (STAGES=1 and STAGES=26) check latency scaling on
// the carry-wrap vector. Streaming and stall sequences are scored against a
// small reference model of the add/subtract.
// ---------------------------------------------------------------------------
module tb_add_subt_pipe;

    localparam int SWR = 26;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           valid_i;
    logic           ready_i;
    logic           op;
    logic [SWR-1:0] a;
    logic [SWR-1:0] b;
    logic           ready_o;
    logic           valid_o;
    logic [SWR-1:0] r_o;
    logic           c_o;
    logic           z_o;

    logic           v1, v26, rdy_x;
    logic           ro1, ro26, vo1, vo26, c1, c26, z1, z26;
    logic [SWR-1:0] r1, r26;
`ifdef ABS_RESULT_EN
    logic           n_o, n1, n26;
`endif

    add_subt_pipe #(.SWR(SWR), .STAGES(2)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
        .Add_Sub_op_i(op), .Data_A_i(a), .Data_B_i(b),
        .valid_o(valid_o), .ready_i(ready_i), .Data_Result_o(r_o),
        .FSM_C_o(c_o),
`ifdef ABS_RESULT_EN
        .Neg_o(n_o),
`endif
        .Zero_o(z_o)
    );

    add_subt_pipe #(.SWR(SWR), .STAGES(1)) dut_s1 (
        .clk(clk), .rst(rst), .valid_i(v1), .ready_o(ro1),
        .Add_Sub_op_i(op), .Data_A_i(a), .Data_B_i(b),
        .valid_o(vo1), .ready_i(rdy_x), .Data_Result_o(r1),
        .FSM_C_o(c1),
`ifdef ABS_RESULT_EN
        .Neg_o(n1),
`endif
        .Zero_o(z1)
    );

    add_subt_pipe #(.SWR(SWR), .STAGES(26)) dut_s26 (
        .clk(clk), .rst(rst), .valid_i(v26), .ready_o(ro26),
        .Add_Sub_op_i(op), .Data_A_i(a), .Data_B_i(b),
        .valid_o(vo26), .ready_i(rdy_x), .Data_Result_o(r26),
        .FSM_C_o(c26),
`ifdef ABS_RESULT_EN
        .Neg_o(n26),
`endif
        .Zero_o(z26)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic           neg;
        logic           zero;
        logic           carry;
        logic [SWR-1:0] res;
    } exp_t;

    // Reference: plain wide arithmetic, A - B done as A + (2^SWR - B).
    function automatic exp_t model(input logic o, input logic [SWR-1:0] x, input logic [SWR-1:0] y);
        logic [SWR:0] s;
        exp_t         e;
        if (o) s = {1'b0, x} + {1'b0, ~y} + (SWR+1)'(1);
        else   s = {1'b0, x} + {1'b0, y};
        e.carry = s[SWR];
        e.res   = s[SWR-1:0];
        e.neg   = 1'b0;
`ifdef ABS_RESULT_EN
        if (o && !e.carry) begin
            e.res = ~e.res + SWR'(1);
            e.neg = 1'b1;
        end
`endif
        e.zero = (e.res == '0);
        return e;
    endfunction

    exp_t exp_q[$];
    int   cyc       = 0;
    int   n_valid   = 0;
    int   n_hs      = 0;
    int   first_hs  = -1;
    int   last_hs   = -1;

    // One cycle of handshake-level traffic: drive at the falling edge, then
    // score what will transfer on the next rising edge.
    task automatic step(input logic rdy, input logic vld, input logic o,
                        input logic [SWR-1:0] x, input logic [SWR-1:0] y);
        exp_t e;
        @(negedge clk);
        ready_i = rdy;
        valid_i = vld;
        op      = o;
        a       = x;
        b       = y;
        #1;
        cyc++;
        if (valid_o) n_valid++;
        if (valid_o && ready_i) begin
            check("sb_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_res", r_o, e.res);
                check("sb_carry", c_o, e.carry);
                check("sb_zero", z_o, e.zero);
`ifdef ABS_RESULT_EN
                check("sb_neg", n_o, e.neg);
`endif
            end
            n_hs++;
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
        end
        if (valid_i && ready_o) exp_q.push_back(model(o, x, y));
    endtask

    // Single isolated operation with latency measurement on the main DUT.
    task automatic run_one(input string tag, input logic o,
                           input logic [SWR-1:0] x, input logic [SWR-1:0] y,
                           input logic [SWR-1:0] er, input logic ec,
                           input logic ez, input logic en);
        int lat;
        @(negedge clk);
        ready_i = 1'b1;
        valid_i = 1'b1;
        op      = o;
        a       = x;
        b       = y;
        lat     = 0;
        for (int i = 1; i <= 50 && lat == 0; i++) begin
            @(negedge clk);
            valid_i = 1'b0;
            if (valid_o) lat = i;
        end
        check({tag, "_lat"}, lat, 2);
        check({tag, "_res"}, r_o, er);
        check({tag, "_carry"}, c_o, ec);
        check({tag, "_zero"}, z_o, ez);
`ifdef ABS_RESULT_EN
        check({tag, "_neg"}, n_o, en);
`else
        if (en) $display("note: %s expects Neg_o only with ABS_RESULT_EN", tag);
`endif
    endtask

    initial begin
        int base_hs;
        int lat1, lat26;
        logic [SWR-1:0] cap_r1, cap_r26;
        logic           cap_c1, cap_c26, cap_z1, cap_z26;
        exp_t           e0;

        rst     = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        op      = 1'b0;
        a       = '0;
        b       = '0;
        v1      = 1'b0;
        v26     = 1'b0;
        rdy_x   = 1'b1;

        // ---------------- reset state ----------------
        #1 rst = 1'b0;
        #2;
        check("rst_valid", valid_o, 0);
        check("rst_res", r_o, 0);
        check("rst_carry", c_o, 0);
        check("rst_zero", z_o, 0);
        check("rst_ready", ready_o, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // ---------------- directed single ops ----------------
        run_one("wrap_add", 1'b0, 26'h3FFFFFF, 26'h0000001, 26'h0000000, 1'b1, 1'b1, 1'b0);
        run_one("sub_5_3", 1'b1, 26'h0000005, 26'h0000003, 26'h0000002, 1'b1, 1'b0, 1'b0);
`ifdef ABS_RESULT_EN
        run_one("sub_3_5", 1'b1, 26'h0000003, 26'h0000005, 26'h0000002, 1'b0, 1'b0, 1'b1);
        run_one("sub_0_1", 1'b1, 26'h0000000, 26'h0000001, 26'h0000001, 1'b0, 1'b0, 1'b1);
`else
        run_one("sub_3_5", 1'b1, 26'h0000003, 26'h0000005, 26'h3FFFFFE, 1'b0, 1'b0, 1'b0);
        run_one("sub_0_1", 1'b1, 26'h0000000, 26'h0000001, 26'h3FFFFFF, 1'b0, 1'b0, 1'b0);
`endif
        run_one("add_mix", 1'b0, 26'h1234567, 26'h0ABCDEF, 26'h1CF1356, 1'b0, 1'b0, 1'b0);
        run_one("sub_eq", 1'b1, 26'h2AAAAAA, 26'h2AAAAAA, 26'h0000000, 1'b1, 1'b1, 1'b0);
        run_one("add_zero", 1'b0, 26'h0000000, 26'h0000000, 26'h0000000, 1'b0, 1'b1, 1'b0);
        run_one("chunk_cy", 1'b0, 26'h0001FFF, 26'h0000001, 26'h0002000, 1'b0, 1'b0, 1'b0);

        // ---------------- 10 back-to-back ops ----------------
        n_valid  = 0;
        n_hs     = 0;
        first_hs = -1;
        last_hs  = -1;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, i[0], SWR'(32'h0ABCDE0 + i * 32'h13579),
                 SWR'(32'h0F00000 - i * 32'h111));
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, '0, '0);
        check("stream_count", n_hs, 10);
        check("stream_valid_cycles", n_valid, 10);
        check("stream_contiguous", last_hs - first_hs, 9);
        check("stream_drained", exp_q.size(), 0);

        // ---------------- stall with full pipe ----------------
        base_hs = n_hs;
        e0      = model(1'b0, 26'h0123456, 26'h0654321);
        step(1'b1, 1'b1, 1'b0, 26'h0123456, 26'h0654321);
        step(1'b1, 1'b1, 1'b1, 26'h2000000, 26'h0000001);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 26'h3000000, 26'h1000000);
            check("stall_ready", ready_o, 0);
            check("stall_valid", valid_o, 1);
            check("stall_res", r_o, e0.res);
            check("stall_carry", c_o, e0.carry);
            check("stall_zero", z_o, e0.zero);
        end
        step(1'b1, 1'b1, 1'b0, 26'h3000000, 26'h1000000);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, '0, '0);
        check("stall_count", n_hs - base_hs, 3);
        check("stall_drained", exp_q.size(), 0);

        // ---------------- reset with ops in flight ----------------
        step(1'b1, 1'b1, 1'b0, 26'h3FFFFFF, 26'h0000002);
        step(1'b1, 1'b1, 1'b0, 26'h0000100, 26'h0000200);
        @(negedge clk);
        valid_i = 1'b0;
        #1;
        check("pre_rst_valid", valid_o, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", valid_o, 0);
        check("mid_rst_res", r_o, 0);
        check("mid_rst_carry", c_o, 0);
        check("mid_rst_zero", z_o, 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        check("held_rst_valid", valid_o, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", ready_o, 1);
        run_one("post_rst", 1'b0, 26'h0001000, 26'h0000FFF, 26'h0001FFF, 1'b0, 1'b0, 1'b0);

        // ---------------- STAGES=1 and STAGES=26 latency ----------------
        @(negedge clk);
        op   = 1'b0;
        a    = 26'h3FFFFFF;
        b    = 26'h0000001;
        v1   = 1'b1;
        v26  = 1'b1;
        lat1  = 0;
        lat26 = 0;
        cap_r1 = '1; cap_r26 = '1;
        cap_c1 = 1'b0; cap_c26 = 1'b0;
        cap_z1 = 1'b0; cap_z26 = 1'b0;
        for (int i = 1; i <= 40 && lat26 == 0; i++) begin
            @(negedge clk);
            v1  = 1'b0;
            v26 = 1'b0;
            if (vo1 && lat1 == 0) begin
                lat1 = i; cap_r1 = r1; cap_c1 = c1; cap_z1 = z1;
            end
            if (vo26 && lat26 == 0) begin
                lat26 = i; cap_r26 = r26; cap_c26 = c26; cap_z26 = z26;
            end
        end
        check("s1_lat", lat1, 1);
        check("s1_res", cap_r1, 0);
        check("s1_carry", cap_c1, 1);
        check("s1_zero", cap_z1, 1);
        check("s26_lat", lat26, 26);
        check("s26_res", cap_r26, 0);
        check("s26_carry", cap_c26, 1);
        check("s26_zero", cap_z26, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
